pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
Multicycle fetch sequencer that owns the architectural PC register and drives the PC_mux select, branch-select and immediate-target inputs.
- Sequences the boot load, then the fetch loop: request to instruction memory, wait for ack, advance PC.
- Buffers one pending redirect (branch) and squashes wrong-path returns.
- Applies stalls and detects instruction-memory timeouts.
- Sits between the decode/branch unit, PC_mux and the instruction-memory port.

Parameters:
TIMEOUT_CYCLES, 16, cycles in WAIT without imem_ack_in before entering ERR (must be at least 2)
CNT_W, 5, width of the timeout counter (must hold TIMEOUT_CYCLES)

Ports:
clk_in  input  1  clock, all state on the rising edge
rst_in  input  1  synchronous, active-high reset
stall_in  input  1  downstream stall; blocks PC advance
branch_taken_in  input  1  redirect request, one-cycle pulse
branch_target_in  input  32  redirect target; bit 0 ignored
pc_mux_in  input  32  PC_mux pc_mux_out (next-PC candidate)
imem_ack_in  input  1  instruction-memory response valid
imem_rdata_in  input  32  instruction-memory read data
pc_out  output  32  PC register; feeds PC_mux pc_in
pc_src_out  output  2  PC_mux pc_src_in
branch_sel_out  output  1  PC_mux branch_taken_in
iaddr_out  output  31  PC_mux iaddr_in (target[31:1])
imem_req_out  output  1  fetch request
imem_addr_out  output  32  fetch address; always equals pc_out
instr_out  output  32  registered fetched instruction
instr_valid_out  output  1  one-cycle pulse, instr_out valid
squash_out  output  1  one-cycle pulse, wrong-path return discarded
fetch_err_out  output  1  sticky timeout error

Behaviour:
- Reset (rst_in=1 at a clock edge):
  - State goes to RST.
  - pc_out=0, pc_src_out=2'b00, branch_sel_out=0, iaddr_out=0, imem_req_out=0, instr_out=0, instr_valid_out=0, squash_out=0, fetch_err_out=0.
  - Pending redirect, squash flag and counter are cleared.
  - Reset overrides every state, including mid-WAIT; any outstanding ack after reset is ignored.
- States: RST, BOOT, WAIT, HOLD, ADV, ERR. All outputs are registered except pc_src_out, branch_sel_out and iaddr_out, which decode from state and pending registers.
- RST:
  - pc_src_out=00.
  - Leaves to BOOT on the first edge with rst_in=0.
- BOOT (one cycle):
  - pc_src_out=00; pc_out<=pc_mux_in (the PC_mux boot address); pending redirect cleared.
  - Next state WAIT.
- WAIT:
  - imem_req_out=1; counter increments each cycle.
  - On imem_ack_in:
    - instr_out<=imem_rdata_in.
    - Next cycle, instr_valid_out=1 if the squash flag is clear; otherwise squash_out=1 and instr_valid_out=0.
    - Counter clears. Next state is ADV if stall_in=0, else HOLD.
  - Counter reaching TIMEOUT_CYCLES-1 with no ack: go to ERR.
- HOLD:
  - imem_req_out=0; pc_out is held.
  - Goes to ADV on the first cycle with stall_in=0.
- ADV (one cycle):
  - pc_src_out=11, branch_sel_out=pend_valid, iaddr_out=pend_target[31:1].
  - pc_out<=pc_mux_in. This is pc_out+4 (modulo 2^32, wraps 0xFFFF_FFFC to 0) or {pend_target[31:1],0}.
  - Pending redirect and squash flag clear. Next state WAIT.
- ERR:
  - imem_req_out=0, fetch_err_out=1.
  - Stays in ERR until reset.
- pc_src_out=11 in WAIT, HOLD and ERR; the mux output is unused in those states.
- Redirect buffer:
  - branch_taken_in in any non-RST/BOOT/ERR state sets pend_valid=1 and pend_target=branch_target_in.
  - The newest request overwrites an older one.
  - If branch_taken_in coincides with ADV, the old pending value is consumed and the new one is re-captured for the next ADV.
- Squash flag:
  - Set by branch_taken_in in WAIT, including the ack cycle itself.
  - Applies to the ack that ends that WAIT.
- Throughput: 2 cycles per instruction minimum (ADV+WAIT, ack in the first WAIT cycle).
- Latency: first imem_req_out is 2 cycles after rst_in falls (RST→BOOT→WAIT).

Test Plan:
1. Boot: bench mux model returns 0x0000_0013 for src 00 and pc_in+4 otherwise; release reset → pc_out=0x0000_0013, imem_req_out=1 with imem_addr_out=0x0000_0013 two cycles after reset release.
2. Sequential: ack every first WAIT cycle with rdata=0xA0+n → instr_valid_out pulses every 2 cycles; pc_out steps 0x13, 0x17, 0x1B; pc_src_out=11 in each ADV.
3. Redirect: branch_taken_in with target 0x0000_1000 during HOLD → next ADV has branch_sel_out=1, iaddr_out=0x0000_0800, pc_out=0x0000_1000; a later ADV has branch_sel_out=0.
4. Squash: branch_taken_in in the same cycle as ack → squash_out=1, instr_valid_out=0; the following fetch is at the target.
5. Stall and timeout:
   - stall_in high for 5 cycles after ack → imem_req_out=0 and pc_out constant; ADV occurs one cycle after release.
   - No ack for 16 cycles → fetch_err_out=1 sticky; reset clears it and reboots.
6. Wrap and mid-op reset: pc_out=0xFFFF_FFFC advance → 0x0000_0000. rst_in asserted mid-WAIT with ack that same cycle → RST values, no instr_valid_out pulse.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Multicycle fetch sequencer: owns the PC register, drives the PC_mux controls and
// the instruction-memory request port, buffers one redirect and squashes wrong-path returns.
module pc_fetch_ctrl #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        stall_in,
    input  logic        branch_taken_in,
    input  logic [31:0] branch_target_in,
    input  logic [31:0] pc_mux_in,
    input  logic        imem_ack_in,
    input  logic [31:0] imem_rdata_in,
    output logic [31:0] pc_out,
    output logic [1:0]  pc_src_out,
    output logic        branch_sel_out,
    output logic [30:0] iaddr_out,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    output logic [31:0] instr_out,
    output logic        instr_valid_out,
    output logic        squash_out,
    output logic        fetch_err_out
);

    localparam logic [2:0] ST_RST  = 3'd0;
    localparam logic [2:0] ST_BOOT = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_HOLD = 3'd3;
    localparam logic [2:0] ST_ADV  = 3'd4;
    localparam logic [2:0] ST_ERR  = 3'd5;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]       state_r;
    logic [31:0]      pc_r;
    logic             req_r;
    logic [31:0]      instr_r;
    logic             instr_valid_r;
    logic             squash_out_r;
    logic             err_r;
    logic             pend_valid_r;
    logic [30:0]      pend_target_r;
    logic             squash_pend_r;
    logic [CNT_W-1:0] cnt_r;
    logic             capture_s;
    logic             target_lsb_unused_s;

    // Redirects are accepted only once the fetch loop is running.
    assign capture_s = branch_taken_in &&
                       ((state_r == ST_WAIT) || (state_r == ST_HOLD) || (state_r == ST_ADV));
    assign target_lsb_unused_s = branch_target_in[0];

    // Sequencer state, PC register, redirect buffer and registered fetch outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r       <= ST_RST;
            pc_r          <= 32'd0;
            req_r         <= 1'b0;
            instr_r       <= 32'd0;
            instr_valid_r <= 1'b0;
            squash_out_r  <= 1'b0;
            err_r         <= 1'b0;
            pend_valid_r  <= 1'b0;
            pend_target_r <= 31'd0;
            squash_pend_r <= 1'b0;
            cnt_r         <= '0;
        end else begin
            instr_valid_r <= 1'b0;
            squash_out_r  <= 1'b0;
            if (capture_s) begin
                pend_valid_r  <= 1'b1;
                pend_target_r <= branch_target_in[31:1];
            end
            case (state_r)
                ST_RST: begin
                    state_r <= ST_BOOT;
                end
                ST_BOOT: begin
                    pc_r          <= pc_mux_in;
                    pend_valid_r  <= 1'b0;
                    pend_target_r <= 31'd0;
                    squash_pend_r <= 1'b0;
                    cnt_r         <= '0;
                    req_r         <= 1'b1;
                    state_r       <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (imem_ack_in) begin
                        instr_r <= imem_rdata_in;
                        // A redirect seen anywhere in this WAIT, ack cycle included, kills the return.
                        if (squash_pend_r || branch_taken_in) begin
                            squash_out_r <= 1'b1;
                        end else begin
                            instr_valid_r <= 1'b1;
                        end
                        squash_pend_r <= 1'b0;
                        cnt_r         <= '0;
                        req_r         <= 1'b0;
                        state_r       <= stall_in ? ST_HOLD : ST_ADV;
                    end else if (cnt_r == CNT_LAST) begin
                        cnt_r   <= '0;
                        req_r   <= 1'b0;
                        err_r   <= 1'b1;
                        state_r <= ST_ERR;
                    end else begin
                        cnt_r         <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        squash_pend_r <= squash_pend_r | branch_taken_in;
                    end
                end
                ST_HOLD: begin
                    if (!stall_in) begin
                        state_r <= ST_ADV;
                    end
                end
                ST_ADV: begin
                    pc_r          <= pc_mux_in;
                    squash_pend_r <= 1'b0;
                    cnt_r         <= '0;
                    req_r         <= 1'b1;
                    state_r       <= ST_WAIT;
                    // The pending redirect is consumed here unless a new one arrives this cycle.
                    if (!branch_taken_in) begin
                        pend_valid_r  <= 1'b0;
                        pend_target_r <= 31'd0;
                    end
                end
                ST_ERR: begin
                    req_r <= 1'b0;
                    err_r <= 1'b1;
                end
                default: begin
                    req_r   <= 1'b0;
                    err_r   <= 1'b1;
                    state_r <= ST_ERR;
                end
            endcase
        end
    end

    // PC_mux controls decode from state and the pending redirect.
    always_comb begin
        pc_src_out     = 2'b11;
        branch_sel_out = 1'b0;
        iaddr_out      = 31'd0;
        if ((state_r == ST_RST) || (state_r == ST_BOOT)) begin
            pc_src_out = 2'b00;
        end else if (state_r == ST_ADV) begin
            branch_sel_out = pend_valid_r;
            iaddr_out      = pend_target_r;
        end else begin
            pc_src_out = 2'b11;
        end
    end

    assign pc_out          = pc_r;
    assign imem_addr_out   = pc_r;
    assign imem_req_out    = req_r;
    assign instr_out       = instr_r;
    assign instr_valid_out = instr_valid_r;
    assign squash_out      = squash_out_r;
    assign fetch_err_out   = err_r;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: models PC_mux, drives directed and randomized fetches,
// and predicts fetch addresses, deliveries, squashes and redirects per instruction.
module tb_pc_fetch_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        stall_in;
    logic        branch_taken_in;
    logic [31:0] branch_target_in;
    logic [31:0] pc_mux_in;
    logic        imem_ack_in;
    logic [31:0] imem_rdata_in;
    logic [31:0] pc_out;
    logic [1:0]  pc_src_out;
    logic        branch_sel_out;
    logic [30:0] iaddr_out;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic [31:0] instr_out;
    logic        instr_valid_out;
    logic        squash_out;
    logic        fetch_err_out;

    int checks = 0;
    int errors = 0;

    // Reference model: next fetch address and the redirect waiting for the next advance.
    logic [31:0] exp_pc;
    logic        m_pend;
    logic [31:0] m_target;

    always #5 clk_in = ~clk_in;

    // PC_mux model: boot vector for src 00, else redirect target or sequential pc+4.
    assign pc_mux_in = (pc_src_out == 2'b00) ? 32'h0000_0013 :
                       (branch_sel_out ? {iaddr_out, 1'b0} : pc_out + 32'd4);

    pc_fetch_ctrl #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .stall_in(stall_in),
        .branch_taken_in(branch_taken_in), .branch_target_in(branch_target_in),
        .pc_mux_in(pc_mux_in), .imem_ack_in(imem_ack_in), .imem_rdata_in(imem_rdata_in),
        .pc_out(pc_out), .pc_src_out(pc_src_out), .branch_sel_out(branch_sel_out),
        .iaddr_out(iaddr_out), .imem_req_out(imem_req_out), .imem_addr_out(imem_addr_out),
        .instr_out(instr_out), .instr_valid_out(instr_valid_out), .squash_out(squash_out),
        .fetch_err_out(fetch_err_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic issue_branch(input logic [31:0] tgt);
        branch_taken_in  = 1'b1;
        branch_target_in = tgt;
        m_pend   = 1'b1;
        m_target = tgt & 32'hFFFF_FFFE;
    endtask

    // Hold reset, check cleared outputs, release and follow RST -> BOOT -> WAIT.
    task automatic do_boot();
        rst_in = 1'b1; stall_in = 1'b0; branch_taken_in = 1'b0; branch_target_in = 32'd0;
        imem_ack_in = 1'b0; imem_rdata_in = 32'd0;
        tick(); tick();
        chk("rst_pc", pc_out, 32'd0);
        chk("rst_src", {30'd0, pc_src_out}, 32'd0);
        chk("rst_req", {31'd0, imem_req_out}, 32'd0);
        chk("rst_err", {31'd0, fetch_err_out}, 32'd0);
        chk("rst_instr", instr_out, 32'd0);
        rst_in = 1'b0;
        tick();
        chk("boot_src", {30'd0, pc_src_out}, 32'd0);
        chk("boot_req", {31'd0, imem_req_out}, 32'd0);
        tick();
        exp_pc = 32'h0000_0013; m_pend = 1'b0; m_target = 32'd0;
    endtask

    // One instruction: delay WAIT cycles, ack, s HOLD cycles, ADV.
    // brp: 0 none, 1 first WAIT cycle, 2 ack cycle, 3 first HOLD cycle, 4 ADV cycle.
    task automatic do_fetch(input int delay, input int s, input int brp,
                            input logic [31:0] tgt, input logic [31:0] d);
        logic        sq;
        logic [31:0] nxt;
        sq = 1'b0;
        chk("wait_req", {31'd0, imem_req_out}, 32'd1);
        chk("wait_addr", imem_addr_out, exp_pc);
        chk("wait_pc", pc_out, exp_pc);
        chk("wait_src", {30'd0, pc_src_out}, 32'd3);
        for (int k = 0; k < delay; k++) begin
            if (brp == 1 && k == 0) begin
                issue_branch(tgt);
                sq = 1'b1;
            end
            tick();
            branch_taken_in = 1'b0;
            chk("wait_req_hold", {31'd0, imem_req_out}, 32'd1);
        end
        imem_ack_in = 1'b1; imem_rdata_in = d; stall_in = (s > 0);
        if (brp == 2 || (brp == 1 && delay == 0)) begin
            issue_branch(tgt);
            sq = 1'b1;
        end
        tick();
        imem_ack_in = 1'b0; branch_taken_in = 1'b0;
        chk("ack_valid", {31'd0, instr_valid_out}, {31'd0, ~sq});
        chk("ack_squash", {31'd0, squash_out}, {31'd0, sq});
        chk("ack_instr", instr_out, d);
        chk("ack_req", {31'd0, imem_req_out}, 32'd0);
        for (int h = 0; h < s; h++) begin
            stall_in = (h < s - 1);
            if (brp == 3 && h == 0) issue_branch(tgt);
            chk("hold_pc", pc_out, exp_pc);
            chk("hold_req", {31'd0, imem_req_out}, 32'd0);
            tick();
            branch_taken_in = 1'b0;
            chk("hold_valid", {31'd0, instr_valid_out}, 32'd0);
        end
        stall_in = 1'b0;
        chk("adv_src", {30'd0, pc_src_out}, 32'd3);
        chk("adv_bsel", {31'd0, branch_sel_out}, {31'd0, m_pend});
        chk("adv_iaddr", {1'b0, iaddr_out}, {1'b0, m_target[31:1]});
        nxt = m_pend ? m_target : exp_pc + 32'd4;
        m_pend = 1'b0; m_target = 32'd0;
        if (brp == 4) issue_branch(tgt);
        tick();
        branch_taken_in = 1'b0;
        exp_pc = nxt;
        chk("post_adv_pulse", {31'd0, instr_valid_out | squash_out}, 32'd0);
    endtask

    initial begin
        int          dly;
        int          stl;
        int          bp;
        logic [31:0] rnd_tgt;

        do_boot();
        do_fetch(0, 0, 0, 32'd0, 32'h0000_00A0);
        do_fetch(0, 0, 0, 32'd0, 32'h0000_00A1);
        do_fetch(0, 0, 0, 32'd0, 32'h0000_00A2);
        // Redirect captured in HOLD, then a plain sequential advance.
        do_fetch(0, 2, 3, 32'h0000_1000, 32'h0000_00A3);
        do_fetch(0, 0, 0, 32'd0, 32'h0000_00A4);
        // Squash on a branch coinciding with the ack.
        do_fetch(1, 0, 2, 32'h0000_2001, 32'h0000_00A5);
        do_fetch(0, 5, 0, 32'd0, 32'h0000_00A6);
        // Branch in ADV carries over to the following advance.
        do_fetch(2, 0, 4, 32'h0000_3000, 32'h0000_00A7);
        do_fetch(0, 0, 0, 32'd0, 32'h0000_00A8);
        // Wrap from 0xFFFF_FFFC to 0.
        do_fetch(0, 0, 2, 32'hFFFF_FFFD, 32'h0000_00A9);
        chk("wrap_at_top", exp_pc, 32'hFFFF_FFFC);
        do_fetch(0, 0, 0, 32'd0, 32'h0000_00AA);
        chk("wrap_pc", pc_out, 32'h0000_0000);

        for (int n = 0; n < 40; n++) begin
            dly = $urandom_range(0, 3);
            stl = $urandom_range(0, 3);
            bp  = $urandom_range(0, 4);
            rnd_tgt = $urandom;
            do_fetch(dly, stl, bp, rnd_tgt, $urandom);
        end

        // Reset mid-WAIT with an ack on the same edge.
        imem_ack_in = 1'b1; imem_rdata_in = 32'hDEAD_BEEF; rst_in = 1'b1;
        tick();
        imem_ack_in = 1'b0;
        chk("midrst_pc", pc_out, 32'd0);
        chk("midrst_valid", {31'd0, instr_valid_out}, 32'd0);
        chk("midrst_instr", instr_out, 32'd0);
        chk("midrst_req", {31'd0, imem_req_out}, 32'd0);
        rst_in = 1'b0;
        tick();
        chk("midrst_boot_valid", {31'd0, instr_valid_out}, 32'd0);
        tick();
        chk("midrst_reboot_pc", pc_out, 32'h0000_0013);
        chk("midrst_reboot_req", {31'd0, imem_req_out}, 32'd1);

        // Timeout: 16 WAIT cycles without ack.
        for (int k = 0; k < 15; k++) tick();
        chk("pre_timeout_err", {31'd0, fetch_err_out}, 32'd0);
        chk("pre_timeout_req", {31'd0, imem_req_out}, 32'd1);
        tick();
        chk("timeout_err", {31'd0, fetch_err_out}, 32'd1);
        chk("timeout_req", {31'd0, imem_req_out}, 32'd0);
        imem_ack_in = 1'b1;
        tick(); tick(); tick();
        imem_ack_in = 1'b0;
        chk("err_sticky", {31'd0, fetch_err_out}, 32'd1);
        chk("err_no_valid", {31'd0, instr_valid_out}, 32'd0);
        do_boot();
        chk("err_cleared", {31'd0, fetch_err_out}, 32'd0);
        do_fetch(0, 0, 0, 32'd0, 32'h0000_00B0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
